seq_int_divider: RTL
====================

# seq_int_divider

Multi-cycle integer divider with per-operation signed/unsigned mode and Verilog division semantics: quotient truncates toward zero, and the remainder takes the sign of the dividend. It is the parametrised, synthesizable successor to the team's fixed-width division-semantics exercises. It sits behind a valid/ready request port and returns the quotient and remainder on a valid/ready response port. Width is generic. Divide-by-zero and signed overflow have defined results.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width. Must be ≥ 2.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request. High only in IDLE.
- `signed_mode`  in  1  1 = operands are two's-complement; 0 = operands are unsigned. Sampled when a request is accepted.
- `dividend`  in  WIDTH  numerator. Sampled when a request is accepted.
- `divisor`  in  WIDTH  denominator. Sampled when a request is accepted.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `quotient`  out  WIDTH  result quotient.
- `remainder`  out  WIDTH  result remainder.
- `div_by_zero`  out  1  the current result came from a zero divisor.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: in_ready = 1.
  - CALC: WIDTH iterations.
  - FIX: sign correction.
  - DONE: out_valid = 1.
- Request accept: when `in_valid && in_ready`, register the operands and the mode.
  - In signed mode, convert each operand to its magnitude and record sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend).
  - In unsigned mode, both sign bits are 0.
  - If divisor == 0, go to DONE. Otherwise go to CALC with the iteration counter = 0.
- CALC performs a restoring shift-subtract of one bit per cycle, MSB first.
  - The partial remainder is WIDTH+1 bits wide.
  - Leave CALC when the counter reaches WIDTH-1.
- FIX:
  - Quotient = sign_q ? −|q| : |q|.
  - Remainder = sign_r ? −|r| : |r|.
  - All results are modulo 2^WIDTH. Go to DONE.
- DONE:
  - Hold out_valid and all result outputs stable until `out_ready` is high, then return to IDLE.
  - A new request cannot be accepted in the same cycle as the result handshake, because in_ready is low in DONE.
- Divide by zero: quotient = all ones, remainder = the dividend unchanged (raw bits), div_by_zero = 1. This holds in both modes.
- Signed overflow (most-negative ÷ −1): quotient = most-negative (wraps), remainder = 0, div_by_zero = 0. No separate flag is raised.
- Magnitude of the most-negative value: treat it as the unsigned value 2^(WIDTH−1). The WIDTH+1-bit datapath handles this with no special case.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, quotient = 0, remainder = 0, div_by_zero = 0.
- Reset mid-operation: an assertion in any state aborts the operation in the next cycle and drives the reset values. No partial result is emitted.
- Inputs are don't-care whenever in_ready = 0.

## Timing
- Normal division: the request handshake occurs at edge 0 and out_valid rises after edge WIDTH+2. Latency is therefore WIDTH+2 cycles: 1 accept cycle, WIDTH CALC cycles and 1 FIX cycle.
- Divide by zero: out_valid rises after edge 1.
- Throughput with out_ready held high: one result per WIDTH+3 cycles. The extra cycle is the DONE→IDLE return.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `div_pkg`:
  - `div_state_t` enum {IDLE, CALC, FIX, DONE}.
  - Function `abs_w` (conditional two's-complement negate).
  - Localparam for the counter width, $clog2(WIDTH).
- Sub-module `div_step`: a combinational single restoring iteration with WIDTH parameter.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
  - `seq_int_divider` instantiates it once and holds the FSM, the counter, the sign registers and the output registers.

## Test plan
- Signed, WIDTH=16: −12 ÷ 3 (0xFFF4 / 0x0003) → quotient 0xFFFC (−4), remainder 0, out_valid 18 cycles after accept.
- Unsigned, WIDTH=16: 65524 ÷ 3 → quotient 21841 (0x5551), remainder 1.
- Signed, WIDTH=4: −4'sd12 (bits 4'b0100 = +4) ÷ 3 → quotient 1, remainder 1. Signed, WIDTH=16: 7 ÷ −2 → quotient −3 (0xFFFD), remainder 1. −7 ÷ 2 → quotient 0xFFFD, remainder 0xFFFF.
- Corner cases, WIDTH=16:
  - 0x8000 ÷ 0xFFFF signed → quotient 0x8000, remainder 0.
  - 0x1234 ÷ 0 → quotient 0xFFFF, remainder 0x1234, div_by_zero = 1, out_valid 1 cycle after accept.
- Backpressure: hold out_ready low for 5 cycles in DONE → outputs are stable and in_ready stays 0. Assert out_ready → the handshake completes and in_ready = 1 in the next cycle.
- Assert rst in the 5th CALC cycle → the next cycle shows IDLE with in_ready = 1, out_valid = 0 and all outputs 0. A subsequent 100 ÷ 7 unsigned request → quotient 14, remainder 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential integer divider.
// Operands up to 64 bits are supported by the magnitude helper.
package div_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

   // Conditional two's-complement negate; callers truncate to their own width.
   function automatic logic [63:0] abs_w(input logic neg, input logic [63:0] val);
      logic [63:0] res;
      if (neg) begin
         res = ~val + 64'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider datapath.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   part_rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH:0]   next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;
   logic           ge_s;

   // Shift in the next dividend bit and subtract when the divisor fits.
   always_comb begin
      shifted_s = {part_rem[WIDTH-1:0], dvd_bit};
      diff_s    = shifted_s - {1'b0, dsr};
      ge_s      = part_rem[WIDTH] | (shifted_s >= {1'b0, dsr});
      if (ge_s) begin
         next_rem = diff_s;
         q_bit    = 1'b1;
      end else begin
         next_rem = shifted_s;
         q_bit    = 1'b0;
      end
   end

endmodule

// File: rtl/seq_int_divider.sv
// Multi-cycle signed/unsigned integer divider with valid/ready request and response ports.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module seq_int_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);

   div_state_t       state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] dvd_r, dsr_r;
   logic             sgn_quo_r, sgn_rem_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;
   logic             in_ready_r, out_valid_r, busy_r, dbz_r;

   logic             accept_s, release_s, zero_div_s, last_s;
   logic             neg_dvd_s, neg_dsr_s;
   logic [WIDTH-1:0] dvd_mag_s, dsr_mag_s, quo_fix_s, rem_fix_s;
   logic [WIDTH:0]   step_rem_s;
   logic             step_q_s;

   div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem (rem_r),
      .dvd_bit  (dvd_r[WIDTH-1]),
      .dsr      (dsr_r),
      .next_rem (step_rem_s),
      .q_bit    (step_q_s)
   );

   // Handshake decodes, operand magnitudes and sign-corrected results.
   always_comb begin
      accept_s   = in_valid && in_ready_r && (state_r == IDLE);
      release_s  = out_valid_r && out_ready;
      zero_div_s = (divisor == {WIDTH{1'b0}});
      last_s     = (cnt_r == CNT_W'(WIDTH - 1));
      neg_dvd_s  = signed_mode & dividend[WIDTH-1];
      neg_dsr_s  = signed_mode & divisor[WIDTH-1];
      dvd_mag_s  = WIDTH'(abs_w(neg_dvd_s, 64'(dividend)));
      dsr_mag_s  = WIDTH'(abs_w(neg_dsr_s, 64'(divisor)));
      quo_fix_s  = WIDTH'(abs_w(sgn_quo_r, 64'(dvd_r)));
      rem_fix_s  = WIDTH'(abs_w(sgn_rem_r, 64'(rem_r[WIDTH-1:0])));
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = zero_div_s ? DONE : CALC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (last_s) begin
               state_nx_s = FIX;
            end else begin
               state_nx_s = CALC;
            end
         end
         FIX:  state_nx_s = DONE;
         DONE: begin
            if (release_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs; status flags track the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         rem_r       <= {(WIDTH + 1){1'b0}};
         dvd_r       <= {WIDTH{1'b0}};
         dsr_r       <= {WIDTH{1'b0}};
         sgn_quo_r   <= 1'b0;
         sgn_rem_r   <= 1'b0;
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
         dbz_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
         busy_r      <= (state_nx_s != IDLE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  cnt_r     <= {CNT_W{1'b0}};
                  rem_r     <= {(WIDTH + 1){1'b0}};
                  dvd_r     <= dvd_mag_s;
                  dsr_r     <= dsr_mag_s;
                  sgn_quo_r <= neg_dvd_s ^ neg_dsr_s;
                  sgn_rem_r <= neg_dvd_s;
                  if (zero_div_s) begin
                     quotient_r  <= {WIDTH{1'b1}};
                     remainder_r <= dividend;
                     dbz_r       <= 1'b1;
                  end
               end
            end
            CALC: begin
               // Quotient bits shift in as dividend bits shift out.
               rem_r <= step_rem_s;
               dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
               cnt_r <= cnt_r + CNT_W'(1);
            end
            FIX: begin
               quotient_r  <= quo_fix_s;
               remainder_r <= rem_fix_s;
               dbz_r       <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign busy        = busy_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;

endmodule
